// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the round-robin FIFO drain arbiter and its pickers.
package fifo_rr_arbiter_pkg;

   localparam int SRC_CNT       = 4;
   localparam int GRANT_W       = 2;
   localparam int MAX_BURST_DEF = 4;
   localparam int BURST_W       = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   function automatic logic [GRANT_W-1:0] next_idx(input logic [GRANT_W-1:0] i);
      return i + 1'b1;
   endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick4.sv
// Circular priority search over four requesters: first set req bit at or after ptr.
module rr_pick4
   import fifo_rr_arbiter_pkg::*;
(
   input  logic [SRC_CNT-1:0] req,
   input  logic [GRANT_W-1:0] ptr,
   output logic [GRANT_W-1:0] idx,
   output logic               found
);

   logic [GRANT_W-1:0] cand;

   always_comb begin
      idx   = ptr;
      found = 1'b0;
      cand  = ptr;
      for (int k = 0; k < SRC_CNT; k++) begin
         cand = ptr + GRANT_W'(k);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of four source FIFOs into one destination FIFO, 2-cycle pop-to-push pipeline.
//   state | meaning
//   IDLE  | choose next non-empty source from rr_ptr (costs one bubble)
//   SERVE | pop granted source while room downstream, up to MAX_BURST words
module fifo_rr_arbiter
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SRC    = SRC_CNT,
   parameter int MAX_BURST  = MAX_BURST_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic [NUM_SRC-1:0]            src_empty,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   input  logic                          dst_full,
   input  logic                          dst_almost_full,
   output logic [NUM_SRC-1:0]            src_rd,
   output logic                          dst_wr,
   output logic [DATA_WIDTH-1:0]         dst_data,
   output logic [GRANT_W-1:0]            grant,
   output logic                          busy,
   output logic                          err_overflow
);

   localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

   state_t             state;
   logic [GRANT_W-1:0] rr_ptr;
   logic [BURST_W-1:0] burst_cnt;
   logic               v1;
   logic [GRANT_W-1:0] g1;
   logic [GRANT_W-1:0] pick_idx;
   logic               pick_found;
   logic               pop;

   rr_pick4 u_pick (
      .req   (~src_empty),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Pop decided combinationally so src_empty seen here always reflects the previous pop.
   assign pop = !reset && (state == SERVE) && en && !src_empty[grant]
                && !dst_almost_full && !dst_full && (burst_cnt < BURST_LIM);

   assign src_rd = pop ? (NUM_SRC'(1) << grant) : '0;
   assign busy   = (state == SERVE) || v1 || dst_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         burst_cnt    <= '0;
         grant        <= '0;
         v1           <= 1'b0;
         g1           <= '0;
         dst_wr       <= 1'b0;
         dst_data     <= '0;
         err_overflow <= 1'b0;
      end else begin
         v1     <= pop;
         g1     <= grant;
         dst_wr <= v1;
         if (v1) begin
            dst_data <= src_data[g1*DATA_WIDTH +: DATA_WIDTH];
         end
         if (dst_wr && dst_full) begin
            err_overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (en && pick_found) begin
                  grant     <= pick_idx;
                  burst_cnt <= '0;
                  state     <= SERVE;
               end
            end
            SERVE: begin
               if (pop) begin
                  burst_cnt <= burst_cnt + 1'b1;
                  // Leave on the last pop of a burst so the switch costs only the IDLE cycle.
                  if (burst_cnt + 1'b1 == BURST_LIM) begin
                     state  <= IDLE;
                     rr_ptr <= next_idx(grant);
                  end
               end else if (!en || src_empty[grant] || (burst_cnt >= BURST_LIM)) begin
                  state  <= IDLE;
                  rr_ptr <= next_idx(grant);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench: behavioural source FIFOs, push/pop logs and hand-computed expected sequences.
module tb_fifo_rr_arbiter;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset, en, dst_full, dst_almost_full;
   logic [3:0]    src_empty = 4'hF;
   logic [4*DW-1:0] src_data = '0;
   logic [3:0]    src_rd;
   logic          dst_wr, busy, err_overflow;
   logic [DW-1:0] dst_data;
   logic [1:0]    grant;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int err_empty  = 0;
   int bad_onehot = 0;
   int busy_fall_cyc = 0;
   logic busy_d = 1'b0;

   logic [7:0] q [4][$];
   logic [7:0] push_q[$];
   int         push_cyc[$];
   int         pop_src[$];
   int         pop_cyc[$];
   logic [7:0] exp_q[$];

   fifo_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(4), .MAX_BURST(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .en              (en),
      .src_empty       (src_empty),
      .src_data        (src_data),
      .dst_full        (dst_full),
      .dst_almost_full (dst_almost_full),
      .src_rd          (src_rd),
      .dst_wr          (dst_wr),
      .dst_data        (dst_data),
      .grant           (grant),
      .busy            (busy),
      .err_overflow    (err_overflow)
   );

   always #5 clk = ~clk;

   // Source FIFOs: synchronous read, empty flag updates the cycle after a pop or push.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (src_rd[i]) begin
            if (q[i].size() == 0) err_empty++;
            else src_data[i*DW +: DW] <= q[i].pop_front();
         end
         src_empty[i] <= (q[i].size() == 0);
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (dst_wr) begin
         push_q.push_back(dst_data);
         push_cyc.push_back(cyc);
      end
      if (src_rd != 4'h0) begin
         if ($countones(src_rd) != 1) bad_onehot++;
         for (int i = 0; i < 4; i++) begin
            if (src_rd[i]) begin
               pop_src.push_back(i);
               pop_cyc.push_back(cyc);
            end
         end
      end
      if (busy_d && !busy) busy_fall_cyc = cyc;
      busy_d = busy;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      push_q.delete();
      push_cyc.delete();
      pop_src.delete();
      pop_cyc.delete();
      exp_q.delete();
   endtask

   task automatic load(input int s, input logic [7:0] base, input int n);
      for (int k = 0; k < n; k++) q[s].push_back(base + 8'(k));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k;
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!busy && q[0].size() == 0 && q[1].size() == 0 &&
             q[2].size() == 0 && q[3].size() == 0) break;
      end
      check({tag, "_done"}, 32'(k < 400), 1);
      tick();
   endtask

   task automatic wait_pop(input string tag);
      int k;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (src_rd != 4'h0) break;
      end
      check({tag, "_pop_seen"}, 32'(k < 50), 1);
   endtask

   task automatic check_pushes(input string tag);
      check({tag, "_npush"}, push_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < push_q.size(); k++)
         check($sformatf("%s_d%0d", tag, k), push_q[k], exp_q[k]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; en = 1'b0; dst_full = 1'b0; dst_almost_full = 1'b0;
      tick();
      tick();
      check("rst_src_rd", src_rd, 0);
      check("rst_dst_wr", dst_wr, 0);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_overflow, 0);

      // Reset mid-burst on src0
      reset = 1'b0; en = 1'b1;
      clear_logs();
      load(0, 8'h10, 5);
      wait_pop("t1");
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("t1_src_rd", src_rd, 0);
      check("t1_dst_wr", dst_wr, 0);
      check("t1_dst_data", dst_data, 0);
      check("t1_grant", grant, 0);
      check("t1_busy", busy, 0);
      en = 1'b0;
      tick();
      reset = 1'b0;
      clear_logs();
      for (int k = 0; k < 6; k++) tick();
      check("t1_no_push", push_q.size(), 0);
      check("t1_idle", busy, 0);
      load(1, 8'hB0, 1);
      en = 1'b1;
      drain("t1");
      check("t1_first_src", pop_src[0], 0);
      check("t1_last_push", push_q[push_q.size()-1], 8'hB0);

      // Single source src2
      clear_logs();
      load(2, 8'hA1, 3);
      drain("t2");
      exp_q = '{8'hA1, 8'hA2, 8'hA3};
      check_pushes("t2");
      check("t2_npop", pop_src.size(), 3);
      for (int k = 0; k < pop_src.size() && k < 3; k++) begin
         check($sformatf("t2_src%0d", k), pop_src[k], 2);
         check($sformatf("t2_lat%0d", k), push_cyc[k] - pop_cyc[k], 2);
      end
      check("t2_back2back", pop_cyc[2] - pop_cyc[0], 2);
      check("t2_grant", grant, 2);

      // Wrap: pointer now 3, only src1 and src3 hold data
      clear_logs();
      load(1, 8'h40, 6);
      load(3, 8'h80, 6);
      drain("t3");
      exp_q = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h40, 8'h41, 8'h42, 8'h43,
                8'h84, 8'h85, 8'h44, 8'h45};
      check_pushes("t3");
      check("t3_g0", pop_src[0], 3);
      check("t3_g1", pop_src[4], 1);
      check("t3_g2", pop_src[8], 3);
      check("t3_g3", pop_src[10], 1);

      // Fairness with burst limit 4, all sources hold 6 words
      do_reset();
      clear_logs();
      for (int s = 0; s < 4; s++) load(s, 8'(s * 16), 6);
      drain("t4");
      for (int s = 0; s < 4; s++)
         for (int k = 0; k < 4; k++) exp_q.push_back(8'(s * 16 + k));
      for (int s = 0; s < 4; s++) begin
         exp_q.push_back(8'(s * 16 + 4));
         exp_q.push_back(8'(s * 16 + 5));
      end
      check_pushes("t4");
      check("t4_burst_rate", pop_cyc[3] - pop_cyc[0], 3);
      check("t4_bubble1", pop_cyc[4] - pop_cyc[3], 2);
      check("t4_bubble2", pop_cyc[8] - pop_cyc[7], 2);
      check("t4_bubble3", pop_cyc[12] - pop_cyc[11], 2);

      // Backpressure mid-burst on src1; src2 waits behind it
      do_reset();
      clear_logs();
      load(1, 8'h50, 4);
      load(2, 8'h60, 2);
      wait_pop("t5");
      tick();
      tick();
      dst_almost_full = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      check("t5_pops_stalled", pop_src.size(), 2);
      check("t5_pushes_stalled", push_q.size(), 2);
      check("t5_grant_held", grant, 1);
      check("t5_busy_held", busy, 1);
      dst_almost_full = 1'b0;
      drain("t5");
      exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61};
      check_pushes("t5");
      check("t5_err", err_overflow, 0);

      // Enable dropped after two pops
      do_reset();
      clear_logs();
      load(0, 8'h70, 6);
      wait_pop("t6");
      tick();
      tick();
      en = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      check("t6_npop", pop_src.size(), 2);
      exp_q = '{8'h70, 8'h71};
      check_pushes("t6");
      check("t6_busy_low", busy, 0);
      check("t6_busy_fall", busy_fall_cyc - push_cyc[1], 1);
      check("t6_left", q[0].size(), 4);
      en = 1'b1;
      drain("t6b");
      check("t6_resume_n", push_q.size(), 6);
      check("t6_resume_last", push_q[push_q.size()-1], 8'h75);

      // Destination full while a word is in flight sets sticky overflow
      clear_logs();
      load(3, 8'hC0, 1);
      wait_pop("t7");
      tick();
      dst_full = 1'b1;
      tick();
      tick();
      check("t7_err_set", err_overflow, 1);
      dst_full = 1'b0;
      tick();
      check("t7_err_sticky", err_overflow, 1);
      do_reset();
      check("t7_err_cleared", err_overflow, 0);

      check("no_empty_pop", err_empty, 0);
      check("src_rd_onehot", bad_onehot, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
